mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating sum of len unsigned 32-bit products
// with a valid/ready result hold and synchronous abort.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   start, len        begin a new sum of len terms (IDLE only)
//   clr               synchronous abort to IDLE, clears the sum
//   prod_in/valid     upstream term, prod_ready = accepting
//   acc_out/valid     result, held until acc_ready
//   busy, overflow    not-IDLE flag, saturation flag
module mac_accumulator #(
    parameter int ACC_W = 40,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             clr,
    input  logic [31:0]      prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             overflow
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             last_term;
    logic [ACC_W:0]   sum_wide;
    logic             sat;

    assign accept    = prod_valid & prod_ready;
    assign last_term = accept && (rem_q == LEN_W'(1));

    // One extra bit catches the carry out of the accumulator.
    assign sum_wide = {1'b0, acc_q}
                    + {{(ACC_W + 1 - 32){1'b0}}, prod_in};
    assign sat      = sum_wide[ACC_W];

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; clr overrides every transition
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (len == '0) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (last_term) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (acc_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (clr) begin
            state_d = S_IDLE;
        end
    end

    // Output logic
    always_comb begin
        prod_ready = (state_q == S_ACCUM) && !clr;
        acc_valid  = (state_q == S_HOLD);
        busy       = (state_q != S_IDLE);
    end

    // Datapath next values
    always_comb begin
        acc_d = acc_q;
        rem_d = rem_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            rem_d = '0;
            ovf_d = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        acc_d = '0;
                        rem_d = len;
                        ovf_d = 1'b0;
                    end
                end
                S_ACCUM: begin
                    if (accept) begin
                        rem_d = rem_q - LEN_W'(1);
                        if (sat) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = sum_wide[ACC_W-1:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            rem_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            rem_q <= rem_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_out  = acc_q;
    assign overflow = ovf_q;

endmodule
